// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU step controller: state encoding and default debounce length.
// The board top and the bench import this so both agree on the encoding.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSE  = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } step_state_e;

    // 10 ms at 50 MHz
    localparam int unsigned DEB_CYCLES_DEF = 500000;

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, debounced level and press pulse.
module btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
            press_d = ~level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the divided slow clock into a one-cycle cpu_en for the core, with run/pause/step/halt
// control from two pushbuttons and a count of issued enables.
//
// state   | meaning
// RUN     | every slow_clk rise issues one cpu_en
// PAUSE   | no enables; waiting for mode (run) or step press
// STEP    | one enable pending on the next slow_clk rise, then back to PAUSE
// HALTED  | core requested halt; only a mode press (to PAUSE) leaves
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned CNT_W         = 32,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             btn_mode,
    input  logic             btn_step,
    input  logic             halt,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);

    localparam step_state_e RESET_STATE = START_RUNNING ? ST_RUN : ST_PAUSE;

    step_state_e      state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q;
    logic [CNT_W-1:0] count_q;
    logic             slow_s1_q, slow_s2_q, slow_prev_q;
    logic             tick;
    logic             mode_level, mode_pulse, step_level, step_pulse;
    logic             mode_press, step_press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_mode),
        .level   (mode_level),
        .press   (mode_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_step),
        .level   (step_level),
        .press   (step_pulse)
    );

    // A press pulse always coincides with the debounced level being high.
    assign mode_press = mode_pulse & mode_level;
    assign step_press = step_pulse & step_level;

    // Sync flops reset high so a slow_clk already high at reset release gives no tick.
    assign tick = slow_s2_q & ~slow_prev_q;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (halt)            state_d = ST_HALTED;
                else if (mode_press) state_d = ST_PAUSE;
                else                 cpu_en_d = tick;
            end
            ST_PAUSE: begin
                if (mode_press)      state_d = ST_RUN;
                else if (step_press) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (tick) begin
                    cpu_en_d = 1'b1;
                    state_d  = mode_press ? ST_RUN : ST_PAUSE;
                end else if (mode_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (mode_press)      state_d = ST_PAUSE;
            end
            default:                 state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_s1_q   <= 1'b1;
            slow_s2_q   <= 1'b1;
            slow_prev_q <= 1'b1;
            state_q     <= RESET_STATE;
            running_q   <= START_RUNNING;
            cpu_en_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            slow_s1_q   <= slow_clk;
            slow_s2_q   <= slow_s1_q;
            slow_prev_q <= slow_s2_q;
            state_q     <= state_d;
            running_q   <= (state_d == ST_RUN);
            cpu_en_q    <= cpu_en_d;
            if (cpu_en_q) count_q <= count_q + 1'b1;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign running     = running_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEB_CYCLES=4, CNT_W=4, slow_clk period of 16 clk.
module tb_cpu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slow_clk = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_step = 1'b0;
    logic       halt = 1'b0;
    logic       cpu_en;
    logic       running;
    logic [3:0] cycle_count;

    int         errors = 0;
    int         checks = 0;
    int         en_cnt = 0;
    int         width_err = 0;
    logic       en_prev = 1'b0;
    logic [3:0] exp_cnt = 4'd0;

    cpu_step_ctrl #(.DEB_CYCLES(4), .CNT_W(4), .START_RUNNING(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .btn_mode    (btn_mode),
        .btn_step    (btn_step),
        .halt        (halt),
        .cpu_en      (cpu_en),
        .running     (running),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_en === 1'b1) en_cnt++;
        if (cpu_en === 1'b1 && en_prev === 1'b1) width_err++;
        en_prev = cpu_en;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slow_period();
        slow_clk = 1'b0;
        clks(8);
        slow_clk = 1'b1;
        clks(8);
    endtask

    task automatic press_mode(input int len);
        btn_mode = 1'b1;
        clks(len);
        btn_mode = 1'b0;
        clks(12);
    endtask

    task automatic press_step(input int len);
        btn_step = 1'b1;
        clks(len);
        btn_step = 1'b0;
        clks(12);
    endtask

    task automatic test_reset();
        int base;
        rst_n = 1'b0; slow_clk = 1'b1;
        clks(3);
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got=%b want=0", cpu_en); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_running got=%b want=1", running); end
        checks++; if (cycle_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", cycle_count); end
        rst_n = 1'b1;
        base = en_cnt;
        clks(10);
        checks++; if (en_cnt - base !== 0) begin errors++; $display("FAIL no_tick_after_reset got=%0d want=0", en_cnt - base); end
        // first rise: cpu_en low after edge 2, high after edge 3, low again after edge 4
        slow_clk = 1'b0;
        clks(8);
        slow_clk = 1'b1;
        clks(2);
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL en_edge2 got=%b want=0", cpu_en); end
        clks(1);
        checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL en_edge3 got=%b want=1", cpu_en); end
        clks(1);
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL en_edge4 got=%b want=0", cpu_en); end
        checks++; if (cycle_count !== 4'd1) begin errors++; $display("FAIL count_first got=%0d want=1", cycle_count); end
        clks(4);
        repeat (4) slow_period();
        exp_cnt = 4'd5;
        checks++; if (en_cnt - base !== 5) begin errors++; $display("FAIL run_pulses got=%0d want=5", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL run_count got=%0d want=%0d", cycle_count, exp_cnt); end
    endtask

    task automatic test_pause();
        int base;
        btn_mode = 1'b1;
        clks(4);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_early got=%b want=1", running); end
        clks(2);
        btn_mode = 1'b0;
        clks(1);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got=%b want=0", running); end
        clks(12);
        base = en_cnt;
        repeat (10) slow_period();
        checks++; if (en_cnt - base !== 0) begin errors++; $display("FAIL pause_pulses got=%0d want=0", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL pause_count got=%0d want=%0d", cycle_count, exp_cnt); end
    endtask

    task automatic test_step();
        int base;
        base = en_cnt;
        press_step(6);
        slow_period();
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (en_cnt - base !== 1) begin errors++; $display("FAIL step1_pulses got=%0d want=1", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL step1_count got=%0d want=%0d", cycle_count, exp_cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL step1_running got=%b want=0", running); end
        slow_period();
        checks++; if (en_cnt - base !== 1) begin errors++; $display("FAIL step_back_to_pause got=%0d want=1", en_cnt - base); end
        press_step(6);
        slow_period();
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (en_cnt - base !== 2) begin errors++; $display("FAIL step2_pulses got=%0d want=2", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL step2_count got=%0d want=%0d", cycle_count, exp_cnt); end
    endtask

    task automatic test_debounce();
        int base;
        base = en_cnt;
        btn_step = 1'b1; clks(2);
        btn_step = 1'b0; clks(1);
        btn_step = 1'b1; clks(2);
        btn_step = 1'b0; clks(12);
        slow_period();
        checks++; if (en_cnt - base !== 0) begin errors++; $display("FAIL glitch_pulses got=%0d want=0", en_cnt - base); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL glitch_running got=%b want=0", running); end
        press_step(5);
        slow_period();
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (en_cnt - base !== 1) begin errors++; $display("FAIL held5_pulses got=%0d want=1", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL held5_count got=%0d want=%0d", cycle_count, exp_cnt); end
    endtask

    task automatic test_halt();
        int base;
        press_mode(6);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL halt_prep_running got=%b want=1", running); end
        base = en_cnt;
        slow_clk = 1'b0;
        clks(8);
        slow_clk = 1'b1;
        clks(2);
        halt = 1'b1;
        clks(1);
        halt = 1'b0;
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL halt_tick_en got=%b want=0", cpu_en); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got=%b want=0", running); end
        clks(5);
        checks++; if (en_cnt - base !== 0) begin errors++; $display("FAIL halt_pulses got=%0d want=0", en_cnt - base); end
        press_step(6);
        slow_period();
        checks++; if (en_cnt - base !== 0) begin errors++; $display("FAIL halted_step got=%0d want=0", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL halted_count got=%0d want=%0d", cycle_count, exp_cnt); end
        press_mode(6);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halted_to_pause got=%b want=0", running); end
        press_step(6);
        slow_period();
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (en_cnt - base !== 1) begin errors++; $display("FAIL halt_then_step got=%0d want=1", en_cnt - base); end
        checks++; if (cycle_count !== exp_cnt) begin errors++; $display("FAIL halt_then_step_count got=%0d want=%0d", cycle_count, exp_cnt); end
    endtask

    task automatic test_wrap_and_reset();
        int base;
        rst_n = 1'b0;
        clks(2);
        checks++; if (cycle_count !== 4'd0) begin errors++; $display("FAIL wrap_reset_count got=%0d want=0", cycle_count); end
        rst_n = 1'b1;
        clks(4);
        repeat (15) slow_period();
        checks++; if (cycle_count !== 4'd15) begin errors++; $display("FAIL preload_count got=%0d want=15", cycle_count); end
        slow_period();
        checks++; if (cycle_count !== 4'd0) begin errors++; $display("FAIL wrap_count got=%0d want=0", cycle_count); end
        press_mode(6);
        press_step(6);
        base = en_cnt;
        slow_clk = 1'b0;
        clks(8);
        slow_clk = 1'b1;
        clks(1);
        rst_n = 1'b0;
        clks(3);
        checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL midreset_en got=%b want=0", cpu_en); end
        rst_n = 1'b1;
        clks(10);
        checks++; if (en_cnt - base !== 0) begin errors++; $display("FAIL midreset_pulses got=%0d want=0", en_cnt - base); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL midreset_running got=%b want=1", running); end
        checks++; if (cycle_count !== 4'd0) begin errors++; $display("FAIL midreset_count got=%0d want=0", cycle_count); end
        slow_period();
        checks++; if (en_cnt - base !== 1) begin errors++; $display("FAIL after_reset_tick got=%0d want=1", en_cnt - base); end
        checks++; if (cycle_count !== 4'd1) begin errors++; $display("FAIL after_reset_count got=%0d want=1", cycle_count); end
    endtask

    initial begin
        test_reset();
        test_pause();
        test_step();
        test_debounce();
        test_halt();
        test_wrap_and_reset();
        checks++; if (width_err !== 0) begin errors++; $display("FAIL en_width got=%0d want=0", width_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
